uart_tx: RTL and testbench
==========================

# uart_tx

Memory-mapped UART transmitter on the data-side peripheral bus at the UART window (0x1000000–0x1000003). It accepts byte writes from the core into a small FIFO and serialises them as 8N1 frames on `uart_txd`. The bit period is derived from the PLL clock, which is also the block's clock, divided down to the configured baud rate.

## Interface
- `clks_per_bit`, 433: bit period minus one, in clock cycles (50 MHz / 115200 − 1).
- `fifo_depth`, 4: TX FIFO entries; power of two, ≥ 2.
- `clock`  in  1  PLL clock; the block runs entirely in this domain.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_valid`  in  1  single-cycle request strobe.
- `uart_instr`  in  1  instruction fetch flag; ignored, treated as data access.
- `uart_addr`  in  32  byte address; only the UART window is routed here; bits ignored.
- `uart_wdata`  in  32  write data; byte in [7:0].
- `uart_wstrb`  in  4  write strobes; nonzero = write, zero = read.
- `uart_rdata`  out  32  read data, valid while `uart_ready`=1.
- `uart_ready`  out  1  single-cycle completion pulse.
- `uart_txd`  out  1  serial output, idle high.

## Operation
- Request capture: `uart_valid`=1 latches addr/wdata/wstrb into a pending register. The master issues no new request until `uart_ready` has pulsed. `uart_valid` while a request is pending is ignored.
- Write (`wstrb`≠0):
  - If `wstrb[0]`=1, push `wdata[7:0]` into the FIFO, then pulse ready.
  - If the FIFO is full, the request stays pending and ready is withheld until a slot frees.
  - If `wstrb[0]`=0, the write is a no-op and is completed without a push.
- Read (`wstrb`=0): completes unconditionally. `rdata[0]` = busy (FSM not IDLE or FIFO non-empty). `rdata[1]` = FIFO full. `rdata[2]` = FIFO empty. Bits [31:3] = 0.
- `uart_rdata` is 0 whenever `uart_ready`=0.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index; full/empty are derived from the pointers.
  - Push and pop in the same cycle are both performed, including when full: the pop frees the slot that the push fills.
  - Pointers wrap modulo 2·`fifo_depth`.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register, go to START, clear the bit counter and baud counter.
  - START: `txd`=0 for `clks_per_bit`+1 cycles, then DATA.
  - DATA: `txd`=shift[0], LSB first. At each bit end, shift right and increment the bit index. After bit 7 ends, go to STOP.
  - STOP: `txd`=1 for `clks_per_bit`+1 cycles. At the end: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0…`clks_per_bit` and resets to 0 at each bit boundary. Its width is $clog2(`clks_per_bit`+1).

## Timing
- Reset values: `uart_txd`=1, `uart_ready`=0, `uart_rdata`=0, FIFO empty, FSM IDLE, no request pending.
- Reset asserted mid-frame: `txd` returns to 1 asynchronously. The frame, FIFO contents and any pending request are discarded.
- Read latency: `valid` at cycle N → `ready`+`rdata` at N+1.
- Write latency, FIFO not full: `valid` at N → push and `ready` at N+1. The FIFO count is visible from N+2.
- Write to a full FIFO: `ready` pulses in the cycle a pop occurs, with the push accepted in that same cycle.
- A push at cycle P into an empty FIFO with the FSM IDLE: pop at P+1, `txd` falls at P+2.
- Frame length: 10·(`clks_per_bit`+1) cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Status reads sample the state at the cycle `ready` is driven.

## Test plan
(All scenarios use `clks_per_bit`=3, `fifo_depth`=4.)
- Reset: assert reset mid-frame → `txd`=1 immediately. After release, a status read returns 0x4 (empty, not busy, not full).
- Single byte: write 0xA5 → `txd` sequence is 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles (40 cycles total). `ready` is high one cycle after `valid`.
- Back-to-back: write 0x00, 0xFF, 0x55 consecutively → three contiguous 40-cycle frames with no idle cycle between stop and start. A status read after all three frames end returns 0x4.
- Full FIFO stall: write 6 bytes rapidly → the 6th write's `ready` is delayed until the second pop, and is asserted the same cycle as that pop. All 6 bytes appear on `txd` in order.
- Status during activity: read immediately after the first write → busy=1, empty=0 or 1 depending on whether the pop has occurred (check that exact cycle). A read with FIFO full returns 0x3.
- Strobe edge: write with `wstrb`=0x2 → `ready` pulses, no push, `txd` stays 1, status 0x4.

Source files
------------

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a single-entry request register feeds a small byte FIFO.
// A start/data/stop serialiser drains the FIFO, clocked by a baud counter derived from the core clock.
module uart_tx #(
  parameter int unsigned clks_per_bit = 433,
  parameter int unsigned fifo_depth   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_txd
);

  localparam int unsigned aw = $clog2(fifo_depth);
  localparam int unsigned bw = $clog2(clks_per_bit + 1);
  localparam logic [bw-1:0] baud_max = bw'(clks_per_bit);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            pend;
  logic [7:0]      pend_byte;
  logic [3:0]      pend_strb;
  logic [7:0]      mem [fifo_depth];
  logic [aw:0]     wptr, rptr;
  logic            empty, full, busy, push, pop, bit_end;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic [bw-1:0]   baud_cnt;
  logic            unused;

  // Address and fetch flag carry no information inside the UART window.
  assign unused = ^{uart_instr, uart_addr, uart_wdata[31:8]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_byte <= '0;
      pend_strb <= '0;
    end else if (!pend) begin
      if (uart_valid) begin
        pend      <= 1'b1;
        pend_byte <= uart_wdata[7:0];
        pend_strb <= uart_wstrb;
      end
    end else if (uart_ready) begin
      pend <= 1'b0;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
  assign busy  = (state != IDLE) || !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (aw+1)'(1);
      if (pop)  rptr <= rptr + (aw+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; occupancy lives in the pointers, so stale bytes are never read.
  always_ff @(posedge clock) begin
    if (push) mem[wptr[aw-1:0]] <= pend_byte;
  end

  // A full FIFO can still accept the pending byte in the cycle the serialiser pops.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    push       = 1'b0;
    uart_ready = 1'b0;
    uart_rdata = '0;
    if (pend) begin
      if (pend_strb == 4'h0) begin
        uart_ready = 1'b1;
        uart_rdata = {29'b0, empty, full, busy};
      end else if (!pend_strb[0]) begin
        uart_ready = 1'b1;
      end else if (!full || pop) begin
        uart_ready = 1'b1;
        push       = 1'b1;
      end
    end
  end

  assign bit_end = (baud_cnt == baud_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (bit_end) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    uart_txd = 1'b1;
    pop      = 1'b0;
    unique case (state)
      IDLE:    pop = !empty;
      START:   uart_txd = 1'b0;
      DATA:    uart_txd = shift[0];
      STOP:    pop = bit_end && !empty;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (pop) begin
      shift    <= mem[rptr[aw-1:0]];
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + bw'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a cycle-level frame/occupancy model predicts bus responses and txd.
// A frame decoder compares every serialised byte against the bytes written.
module tb_uart_tx;

  localparam int CPB   = 3;
  localparam int DEPTH = 4;
  localparam int BIT   = CPB + 1;
  localparam int FRAME = 10 * BIT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        uart_valid = 1'b0;
  logic        uart_instr = 1'b0;
  logic [31:0] uart_addr  = '0;
  logic [31:0] uart_wdata = '0;
  logic [3:0]  uart_wstrb = '0;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        uart_txd;

  uart_tx #(.clks_per_bit(CPB), .fifo_depth(DEPTH)) dut (
    .clock(clock), .reset(reset), .uart_valid(uart_valid), .uart_instr(uart_instr),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb),
    .uart_rdata(uart_rdata), .uart_ready(uart_ready), .uart_txd(uart_txd)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        txd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];

  // Reference model: FIFO as a queue, the frame as a count of remaining cycles.
  logic [7:0] m_fifo[$];
  int         m_rem = 0;
  logic [7:0] m_cur = '0;
  bit         m_pend = 0;
  logic [3:0] m_ws = '0;
  logic [7:0] m_wd = '0;
  int         m_sz, m_k;
  bit         m_full, m_empty, m_busy, m_pop, m_push;
  exp_t       m_e;

  always @(negedge clock) begin
    if (reset) begin
      m_fifo.delete();
      exp_q.delete();
      m_rem  = 0;
      m_pend = 0;
    end else begin
      m_sz    = m_fifo.size();
      m_full  = (m_sz == DEPTH);
      m_empty = (m_sz == 0);
      m_busy  = (m_rem > 0) || !m_empty;
      m_pop   = !m_empty && (m_rem <= 1);
      m_push  = 0;
      m_e.ready = 1'b0;
      m_e.rdata = '0;
      if (m_rem == 0) m_e.txd = 1'b1;
      else begin
        m_k = (FRAME - m_rem) / BIT;
        m_e.txd = (m_k == 0) ? 1'b0 : (m_k == 9) ? 1'b1 : m_cur[m_k-1];
      end
      if (m_pend) begin
        if (m_ws == 4'h0) begin
          m_e.ready = 1'b1;
          m_e.rdata = {29'b0, m_empty, m_full, m_busy};
        end else if (!m_ws[0]) m_e.ready = 1'b1;
        else if (!m_full || m_pop) begin
          m_e.ready = 1'b1;
          m_push = 1;
        end
      end
      exp_q.push_back(m_e);
      if (m_pop) begin
        m_cur = m_fifo.pop_front();
        m_rem = FRAME;
      end else if (m_rem > 0) m_rem--;
      if (m_push) m_fifo.push_back(m_wd);
      if (!m_pend) begin
        if (uart_valid) begin
          m_pend = 1;
          m_ws   = uart_wstrb;
          m_wd   = uart_wdata[7:0];
        end
      end else if (m_e.ready) m_pend = 0;
    end
  end

  // Monitor: per-cycle comparison against the model plus frame decoding against written bytes.
  bit         in_fr = 0;
  int         fr_t = 0;
  logic [7:0] fr_byte = '0;
  exp_t       mon_e;

  always @(negedge clock) begin
    #1;
    if (reset) in_fr = 0;
    else begin
      if (exp_q.size() == 0) check("exp_queue_empty", 32'd0, 32'd1);
      else begin
        mon_e = exp_q.pop_front();
        check("ready", uart_ready, mon_e.ready);
        check("rdata", uart_rdata, mon_e.rdata);
        check("txd", uart_txd, mon_e.txd);
      end
      if (!in_fr) begin
        if (uart_txd == 1'b0) begin
          in_fr = 1;
          fr_t  = 0;
        end
      end else fr_t++;
      if (in_fr) begin
        if (fr_t >= BIT && fr_t < 9*BIT && (fr_t % BIT) == BIT/2)
          fr_byte = {uart_txd, fr_byte[7:1]};
        if (fr_t == 9*BIT + BIT/2) begin
          check("stop_bit", uart_txd, 1'b1);
          if (byte_q.size() == 0) check("unexpected_frame", {24'b0, fr_byte}, 32'hFFFF_FFFF);
          else check("frame_byte", fr_byte, byte_q.pop_front());
        end
        if (fr_t == FRAME - 1) in_fr = 0;
      end
    end
  end

  task automatic bus(input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd, output int n);
    @(posedge clock); #1;
    uart_valid = 1'b1;
    uart_wstrb = s;
    uart_wdata = d;
    uart_addr  = 32'h0100_0000 + $urandom_range(0, 3);
    uart_instr = 1'($urandom);
    if (s[0]) byte_q.push_back(d[7:0]);
    @(posedge clock); #1;
    uart_valid = 1'b0;
    uart_wdata = $urandom;
    n = 0;
    while (!uart_ready && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    check("bus_timeout", 32'(n < 300), 32'd1);
    rd = uart_rdata;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((byte_q.size() != 0 || m_rem != 0 || m_fifo.size() != 0) && n < 5000) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", 32'(n < 5000), 32'd1);
  endtask

  logic [31:0] rd;
  int          n;
  logic [3:0]  s;
  int          r;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset_txd", uart_txd, 1'b1);
    check("reset_ready", uart_ready, 1'b0);
    check("reset_rdata", uart_rdata, 32'h0);
    @(posedge clock); #2;
    reset = 1'b0;

    bus(4'h0, 32'h0, rd, n);
    check("status_after_reset", rd, 32'h4);
    check("read_latency", n, 0);

    bus(4'h1, 32'hA5, rd, n);
    check("write_latency", n, 0);
    bus(4'h0, 32'h0, rd, n);
    check("status_after_first_write", rd, 32'h5);
    wait_idle();

    bus(4'h1, 32'h00, rd, n);
    bus(4'h1, 32'hFF, rd, n);
    bus(4'h1, 32'h55, rd, n);
    wait_idle();
    bus(4'h0, 32'h0, rd, n);
    check("status_after_b2b", rd, 32'h4);

    for (int i = 0; i < 6; i++) bus(4'hF, $urandom, rd, n);
    check("full_stall_wait", n, 31);
    bus(4'h0, 32'h0, rd, n);
    check("status_full", rd, 32'h3);
    wait_idle();

    bus(4'h2, 32'h77, rd, n);
    check("strobe_latency", n, 0);
    repeat (20) @(posedge clock);
    bus(4'h0, 32'h0, rd, n);
    check("status_after_strobe", rd, 32'h4);

    bus(4'h1, 32'h00, rd, n);
    bus(4'h1, 32'h3C, rd, n);
    n = 0;
    while (uart_txd && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    repeat (6) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("txd_async_reset", uart_txd, 1'b1);
    check("ready_in_reset", uart_ready, 1'b0);
    byte_q.delete();
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    bus(4'h0, 32'h0, rd, n);
    check("status_after_midframe_reset", rd, 32'h4);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      s = 4'($urandom_range(0, 7) * 2 + 1);
      else if (r < 85) s = 4'h0;
      else             s = 4'($urandom_range(1, 7) * 2);
      bus(s, $urandom, rd, n);
      repeat ($urandom_range(0, 12)) @(posedge clock);
    end
    wait_idle();
    bus(4'h0, 32'h0, rd, n);
    check("status_final", rd, 32'h4);

    repeat (4) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
